// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit: main FSM, ALU decoder and condition check.
// It drives all datapath selects and write enables, and it holds the NZCV flags.
module arm_multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic        Illegal
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    state_t      state, state_next, ctl_state;
    logic [3:0]  flags;
    logic        cond_ex_q;
    logic        cond_ex;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        rd_pc;
    logic        unused_rn;

    logic        next_pc, branch, reg_w, mem_w, ir_write, alu_op;
    logic [1:0]  flag_w;
    logic        pcs;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];
    assign rd_pc     = (rd == 4'hF);

    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] nzcv);
        logic n, z, cf, v;
        {n, z, cf, v} = nzcv;
        case (c)
            4'b0000: cond_check = z;
            4'b0001: cond_check = ~z;
            4'b0010: cond_check = cf;
            4'b0011: cond_check = ~cf;
            4'b0100: cond_check = n;
            4'b0101: cond_check = ~n;
            4'b0110: cond_check = v;
            4'b0111: cond_check = ~v;
            4'b1000: cond_check = cf & ~z;
            4'b1001: cond_check = ~cf | z;
            4'b1010: cond_check = (n == v);
            4'b1011: cond_check = (n != v);
            4'b1100: cond_check = ~z & (n == v);
            4'b1101: cond_check = z | (n != v);
            4'b1110: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

    // Returns {ALUControl, FlagW}
    function automatic logic [3:0] alu_decode(input logic aop, input logic [5:0] f);
        logic [1:0] ctrl;
        logic [1:0] fw;
        ctrl = 2'b00;
        fw   = 2'b00;
        if (aop) begin
            case (f[4:1])
                4'b0100: ctrl = 2'b00;
                4'b0010: ctrl = 2'b01;
                4'b0000: ctrl = 2'b10;
                4'b1100: ctrl = 2'b11;
                default: ctrl = 2'b00;
            endcase
            fw[1] = f[0];
            fw[0] = f[0] & ((f[4:1] == 4'b0100) | (f[4:1] == 4'b0010));
        end
        alu_decode = {ctrl, fw};
    endfunction

    assign cond_ex = cond_check(cond, flags);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            flags     <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE)
                cond_ex_q <= cond_ex;
            if ((state == EXECUTER) || (state == EXECUTEI)) begin
                if (flag_w[1] & cond_ex_q)
                    flags[3:2] <= ALUFlags[3:2];
                if (flag_w[0] & cond_ex_q)
                    flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (op)
                    2'b00:   state_next = funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = UNKNOWN;
                endcase
            end
            MEMADR:   state_next = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            default:  state_next = FETCH;
        endcase
    end

    // While reset is held the selects show FETCH values; enables are masked below.
    assign ctl_state = reset ? FETCH : state;

    always_comb begin
        next_pc   = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        ir_write  = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        Illegal   = 1'b0;
        case (ctl_state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = 1'b1;
                next_pc   = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            ALUWB:    reg_w = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            UNKNOWN:  Illegal = 1'b1;
            default: ;
        endcase
    end

    assign {ALUControl, flag_w} = alu_decode(alu_op, funct);

    assign RegSrc = {(op == 2'b01), (op == 2'b10)};
    assign ImmSrc = op;

    assign pcs      = (rd_pc & reg_w) | branch;
    assign PCWrite  = ~reset & (next_pc | (pcs & cond_ex_q));
    assign RegWrite = ~reset & reg_w & cond_ex_q & ~rd_pc;
    assign MemWrite = ~reset & mem_w & cond_ex_q;
    assign IRWrite  = ~reset & ir_write;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Scoreboard bench for arm_multicycle_controller: an instruction-level model
// queues expected per-cycle controls, and a negedge monitor compares them.
module tb_arm_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, Illegal;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    arm_multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    logic [3:0] m_flags = 4'b0000;
    bit         m_cex   = 1'b0;

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl,Illegal}
    function automatic logic [16:0] pack(input bit pcw, input bit mw, input bit rw, input bit irw,
                                          input bit adr, input logic [1:0] rsrc, input bit asa,
                                          input logic [1:0] asb, input logic [1:0] res,
                                          input logic [1:0] imm, input logic [1:0] aluc, input bit ill);
        return {pcw, mw, rw, irw, adr, rsrc, asa, asb, res, imm, aluc, ill};
    endfunction

    function automatic bit condex(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_cmd(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b01 - 2'b01;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic step(input logic [16:0] v, input string nm, input bit rst,
                        input logic [19:0] ins, input logic [3:0] af);
        exp_t e;
        reset    = rst;
        Instr    = ins;
        ALUFlags = af;
        e.v  = v;
        e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One instruction, built from its class; rst_at asserts reset in that cycle.
    task automatic run_instr(input logic [19:0] ins, input logic [3:0] af_fix,
                             input bit rnd_af, input int rst_at);
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        bit          rdpc;
        logic [1:0]  rsrc;
        logic [3:0]  af;
        logic [16:0] v;
        string       ph[$];
        cond  = ins[19:16];
        op    = ins[15:14];
        funct = ins[13:8];
        rdpc  = (ins[3:0] == 4'hF);
        rsrc  = {op == 2'b01, op == 2'b10};
        ph.push_back("FETCH");
        ph.push_back("DECODE");
        case (op)
            2'b00: begin
                ph.push_back(funct[5] ? "EXECI" : "EXECR");
                ph.push_back("ALUWB");
            end
            2'b01: begin
                ph.push_back("MEMADR");
                if (funct[0]) begin
                    ph.push_back("MEMREAD");
                    ph.push_back("MEMWB");
                end else begin
                    ph.push_back("MEMWRITE");
                end
            end
            2'b10: ph.push_back("BRANCH");
            default: ph.push_back("UNKNOWN");
        endcase
        foreach (ph[i]) begin
            af = rnd_af ? 4'($urandom) : af_fix;
            if (i == rst_at) begin
                v = pack(0, 0, 0, 0, 0, rsrc, 1, 2'b10, 2'b10, op, 2'b00, 0);
                step(v, $sformatf("RESET_in_%s_%05h", ph[i], ins), 1'b1, ins, af);
                reset   = 1'b0;
                m_flags = 4'b0000;
                m_cex   = 1'b0;
                return;
            end
            v = pack(0, 0, 0, 0, 0, rsrc, 0, 2'b00, 2'b00, op, 2'b00, 0);
            case (ph[i])
                "FETCH":    v = pack(1, 0, 0, 1, 0, rsrc, 1, 2'b10, 2'b10, op, 2'b00, 0);
                "DECODE": begin
                    v = pack(0, 0, 0, 0, 0, rsrc, 1, 2'b10, 2'b10, op, 2'b00, 0);
                    m_cex = condex(cond, m_flags);
                end
                "EXECR":    v = pack(0, 0, 0, 0, 0, rsrc, 0, 2'b00, 2'b00, op, alu_cmd(funct[4:1]), 0);
                "EXECI":    v = pack(0, 0, 0, 0, 0, rsrc, 0, 2'b01, 2'b00, op, alu_cmd(funct[4:1]), 0);
                "ALUWB":    v = pack(m_cex && rdpc, 0, m_cex && !rdpc, 0, 0, rsrc, 0, 2'b00, 2'b00, op, 2'b00, 0);
                "MEMADR":   v = pack(0, 0, 0, 0, 0, rsrc, 0, 2'b01, 2'b00, op, 2'b00, 0);
                "MEMREAD":  v = pack(0, 0, 0, 0, 1, rsrc, 0, 2'b00, 2'b00, op, 2'b00, 0);
                "MEMWB":    v = pack(m_cex && rdpc, 0, m_cex && !rdpc, 0, 0, rsrc, 0, 2'b00, 2'b01, op, 2'b00, 0);
                "MEMWRITE": v = pack(0, m_cex, 0, 0, 1, rsrc, 0, 2'b00, 2'b00, op, 2'b00, 0);
                "BRANCH":   v = pack(m_cex, 0, 0, 0, 0, rsrc, 0, 2'b01, 2'b10, op, 2'b00, 0);
                "UNKNOWN":  v = pack(0, 0, 0, 0, 0, rsrc, 0, 2'b00, 2'b00, op, 2'b00, 1);
                default: ;
            endcase
            step(v, $sformatf("%s_%05h", ph[i], ins), 1'b0, ins, af);
            // Flags written by an S-suffixed ADD/SUB (all NZCV) or logical op (NZ only)
            if ((ph[i] == "EXECR" || ph[i] == "EXECI") && m_cex && funct[0]) begin
                m_flags[3:2] = af[3:2];
                if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010)
                    m_flags[1:0] = af[1:0];
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [16:0] got;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
                   ResultSrc, ImmSrc, ALUControl, Illegal};
            checks++;
            if (got === e.v)
                passed++;
            else
                $display("FAIL %s got=%05h expected=%05h", e.nm, got, e.v);
        end
    end

    initial begin
        logic [19:0] ins;
        int          rst_at;
        reset    = 1'b1;
        Instr    = 20'h0;
        ALUFlags = 4'h0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            step(pack(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0), "RESET_HOLD",
                 1'b1, 20'h0, 4'h0);
        m_flags = 4'b0000;
        m_cex   = 1'b0;

        run_instr(20'hE2821, 4'h0, 1'b1, -1);   // ADD R1,R2,#5
        run_instr(20'hE2532, 4'b0100, 1'b0, -1); // SUBS -> Z set
        run_instr(20'h0A000, 4'h0, 1'b1, -1);    // BEQ taken
        run_instr(20'hE2532, 4'b0000, 1'b0, -1); // SUBS -> Z clear
        run_instr(20'h0A000, 4'h0, 1'b1, -1);    // BEQ not taken
        run_instr(20'hE5910, 4'h0, 1'b1, -1);    // LDR
        run_instr(20'hE5810, 4'h0, 1'b1, -1);    // STR
        run_instr(20'h02821, 4'h0, 1'b1, -1);    // ADDEQ with Z=0
        run_instr(20'hE282F, 4'h0, 1'b1, -1);    // ADD to R15
        run_instr(20'hEC000, 4'h0, 1'b1, -1);    // Op=11
        run_instr(20'hE5810, 4'h0, 1'b1, 3);     // reset during MEMWRITE
        run_instr(20'hE2821, 4'h0, 1'b1, -1);

        for (int n = 0; n < 300; n++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 2) == 0)
                ins[19:16] = 4'hE;
            if ($urandom_range(0, 5) == 0)
                ins[3:0] = 4'hF;
            rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(ins, 4'h0, 1'b1, rst_at);
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++)
            @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
